shr_pattern_gen: RTL and testbench

Parametrised serial pattern generator for shift-register (SHR) control on the DE0 platform. It captures a wide data word on trigger and shifts it out on NCH parallel data lines with a shared serial clock, then issues a sync/latch strobe. It adds a programmable clock divider, bit-order select, frame repeat, abort and a busy/done handshake. Output enables feed the top-level tristate buffers on the GPIO pins.

---
 rtl/shr_pattern_gen.sv | 136 +++++++++++++
 tb/tb_shr_pattern_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shr_pattern_gen.sv
// Serial pattern generator for shift-register control: shifts a captured frame out on
// NCH data lines with a shared divided serial clock, then a sync strobe, optionally repeated.
module shr_pattern_gen #(
  parameter int unsigned NBITS = 620,
  parameter int unsigned NCH   = 1,
  parameter int unsigned CNT_W = 10,
  parameter int unsigned DIV_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [NCH*NBITS-1:0] data_reg,
  input  logic                 trig,
  input  logic                 clr_mode,
  input  logic                 clr_2_one,
  input  logic                 msb_first,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic [7:0]           repeat_cnt,
  input  logic                 abort,
  output logic                 sclk,
  output logic [NCH-1:0]       din,
  output logic                 syn,
  output logic                 out_en,
  output logic                 clk_out_en,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SHIFT, SYNC, GAP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  state_t               state, state_next;
  logic                 trig_q;
  logic [NCH*NBITS-1:0] shadow;
  logic                 clr_mode_l, clr_2_one_l, msb_first_l;
  logic [DIV_W-1:0]     clk_div_l, div_cnt;
  logic [7:0]           rep_left;
  logic                 phase;
  logic [CNT_W-1:0]     idx, sel;
  logic [NBITS-1:0]     word;
  logic                 tick, bit_end, start;

  assign tick    = (div_cnt == clk_div_l);
  // phase 0/1 are the two half-periods of a bit; a bit period ends on the phase-1 tick
  assign bit_end = tick & phase;
  assign start   = trig & ~trig_q & ~abort;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (abort) state_next = IDLE;
               else if (bit_end && idx == LAST) state_next = SYNC;
      SYNC:    if (abort) state_next = IDLE;
               else if (bit_end) state_next = (rep_left != '0) ? GAP : IDLE;
      GAP:     if (abort) state_next = IDLE;
               else if (bit_end) state_next = SHIFT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      trig_q      <= 1'b0;
      shadow      <= '0;
      clr_mode_l  <= 1'b0;
      clr_2_one_l <= 1'b0;
      msb_first_l <= 1'b0;
      clk_div_l   <= '0;
      rep_left    <= '0;
      div_cnt     <= '0;
      phase       <= 1'b0;
      idx         <= '0;
      done        <= 1'b0;
    end else begin
      trig_q <= trig;
      done   <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        phase   <= 1'b0;
        idx     <= '0;
        if (start) begin
          shadow      <= data_reg;
          clr_mode_l  <= clr_mode;
          clr_2_one_l <= clr_2_one;
          msb_first_l <= msb_first;
          clk_div_l   <= clk_div;
          rep_left    <= repeat_cnt;
        end
      end else if (abort) begin
        div_cnt <= '0;
        phase   <= 1'b0;
        idx     <= '0;
      end else begin
        if (tick) begin
          div_cnt <= '0;
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (bit_end) begin
          case (state)
            SHIFT:   idx <= (idx == LAST) ? '0 : idx + CNT_W'(1);
            SYNC:    if (rep_left != '0) rep_left <= rep_left - 8'd1;
                     else done <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign sel = msb_first_l ? (LAST - idx) : idx;

  always_comb begin
    busy       = (state != IDLE);
    out_en     = (state != IDLE);
    clk_out_en = (state == SHIFT);
    sclk       = (state == SHIFT) & phase;
    syn        = (state == SYNC) & ~clr_mode_l;
    din        = '0;
    word       = '0;
    if (state == SHIFT) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        word   = shadow[c*NBITS +: NBITS] >> sel;
        din[c] = clr_mode_l ? clr_2_one_l : word[0];
      end
    end
  end

endmodule

// File: tb/tb_shr_pattern_gen.sv
// Self-checking bench for shr_pattern_gen: random and directed frames compared cycle by
// cycle against a timing model derived from frame/bit-period arithmetic.
module tb_shr_pattern_gen;

  localparam int unsigned NB = 8;
  localparam int unsigned NC = 2;

  logic            clk_in = 1'b0;
  logic            rst_n;
  logic [NC*NB-1:0] data_reg;
  logic            trig, clr_mode, clr_2_one, msb_first, abort;
  logic [7:0]      clk_div, repeat_cnt;
  logic            sclk, syn, out_en, clk_out_en, busy, done;
  logic [NC-1:0]   din;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  shr_pattern_gen #(.NBITS(NB), .NCH(NC), .CNT_W(4), .DIV_W(8)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_reg(data_reg), .trig(trig),
    .clr_mode(clr_mode), .clr_2_one(clr_2_one), .msb_first(msb_first),
    .clk_div(clk_div), .repeat_cnt(repeat_cnt), .abort(abort),
    .sclk(sclk), .din(din), .syn(syn), .out_en(out_en),
    .clk_out_en(clk_out_en), .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  // {busy, out_en, clk_out_en, sclk, syn, din[1:0], done}
  function automatic logic [7:0] observed();
    return {busy, out_en, clk_out_en, sclk, syn, din, done};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  // Expected outputs k cycles after the accepting edge (k=0 is the first busy cycle).
  function automatic logic [7:0] model(input logic [15:0] d, input logic cm, c2o, msb,
                                       input int unsigned dv, rp, k);
    int unsigned hp, bp, fr, per, tot, r, b;
    logic [1:0] dn;
    logic sc;
    hp  = dv + 1;
    bp  = 2 * hp;
    fr  = (NB + 1) * bp;
    per = fr + bp;
    tot = (rp + 1) * fr + rp * bp;
    if (k == tot) return 8'b0000_0001;
    if (k > tot)  return 8'b0;
    r = k % per;
    if (r < NB * bp) begin
      b  = r / bp;
      sc = ((r % bp) >= hp);
      for (int c = 0; c < NC; c++)
        dn[c] = cm ? c2o : d[c*NB + (msb ? (NB - 1 - b) : b)];
      return {1'b1, 1'b1, 1'b1, sc, 1'b0, dn, 1'b0};
    end
    if (r < fr) return {1'b1, 1'b1, 1'b0, 1'b0, ~cm, 2'b00, 1'b0};
    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
  endfunction

  task automatic run_seq(input logic [15:0] d, input logic cm, c2o, msb,
                         input logic [7:0] dv, rp, input bit disturb);
    int unsigned tot;
    trig = 1'b0;
    @(negedge clk_in);
    data_reg = d; clr_mode = cm; clr_2_one = c2o; msb_first = msb;
    clk_div = dv; repeat_cnt = rp; abort = 1'b0; trig = 1'b1;
    @(posedge clk_in);
    tot = (int'(rp) + 1) * (NB + 1) * 2 * (int'(dv) + 1) + int'(rp) * 2 * (int'(dv) + 1);
    for (int unsigned k = 0; k <= tot + 2; k++) begin
      @(negedge clk_in);
      check("seq", observed(), model(d, cm, c2o, msb, dv, rp, k));
      if (disturb) begin
        if (k == 2) trig = 1'b0;
        if (k == 3) begin
          data_reg = 16'($urandom); clr_mode = ~cm; msb_first = ~msb;
          clk_div = 8'($urandom_range(0, 3)); repeat_cnt = 8'($urandom_range(0, 2));
        end
        if (k == 4) trig = 1'b1;
        if (k == 6) trig = 1'b0;
      end
    end
    trig = 1'b0;
  endtask

  always @(negedge clk_in)
    if (rst_n && clk_out_en) assert (dut.idx <= 4'(NB - 1)) else $error("bit index out of range");

  initial begin
    logic [15:0] d;
    rst_n = 1'b0; trig = 1'b0; abort = 1'b0; data_reg = '0; clr_mode = 1'b0;
    clr_2_one = 1'b0; msb_first = 1'b0; clk_div = '0; repeat_cnt = '0;
    repeat (3) @(negedge clk_in);
    check("reset", observed(), 8'b0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("idle", observed(), 8'b0);

    run_seq({8'h3C, 8'hA5}, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    run_seq(16'h0081, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0, 1'b1);
    run_seq(16'h1234, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    run_seq(16'hFFFF, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0);
    run_seq(16'hC3A7, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0);

    // abort at start of bit 4, then no done afterwards
    trig = 1'b0;
    @(negedge clk_in);
    data_reg = 16'h5A96; clr_mode = 1'b0; msb_first = 1'b0; clk_div = 8'd1;
    repeat_cnt = 8'd1; trig = 1'b1;
    @(posedge clk_in);
    for (int unsigned k = 0; k <= 16; k++) begin
      @(negedge clk_in);
      check("pre_abort", observed(), model(16'h5A96, 1'b0, 1'b0, 1'b0, 1, 1, k));
    end
    abort = 1'b1;
    @(negedge clk_in);
    check("abort", observed(), 8'b0);
    abort = 1'b0; trig = 1'b0;
    repeat (6) begin
      @(negedge clk_in);
      check("post_abort", observed(), 8'b0);
    end

    // abort beats a simultaneous trigger edge in IDLE
    trig = 1'b1; abort = 1'b1;
    @(negedge clk_in);
    check("abort_prio", observed(), 8'b0);
    abort = 1'b0;
    @(negedge clk_in);
    check("abort_drop", observed(), 8'b0);
    run_seq(16'h0F0F, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk_in);
    data_reg = 16'hFFFF; clr_mode = 1'b0; clk_div = 8'd2; repeat_cnt = 8'd0; trig = 1'b1;
    @(posedge clk_in);
    repeat (5) @(negedge clk_in);
    check("pre_rst", observed(), model(16'hFFFF, 1'b0, 1'b0, msb_first, 2, 0, 4));
    #2 rst_n = 1'b0;
    #1 check("async_rst", observed(), 8'b0);
    @(negedge clk_in);
    rst_n = 1'b1;
    trig = 1'b0;
    @(negedge clk_in);
    check("post_rst", observed(), 8'b0);
    run_seq(16'h6E19, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      run_seq(d, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
              8'($urandom_range(0, 3)), 8'($urandom_range(0, 2)), bit'(i % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
